trng_host_ctrl: RTL and testbench

Bus-initiator sequencer for the TRNG peripheral register interface. It drives the peripheral-side bus (`address`, `data_in`, `data_write_n`, `data_read_n`; samples `data_out`, `data_ready`) through the full programming sequence: reset, load configuration, enable, poll status, request a word and read it. Each captured 32-bit random word is delivered on a valid/ready stream. It is used in the standalone TRNG test harness and in any integration where a core is not present to run firmware.

---
 rtl/trng_host_pkg.sv | 42 ++++
 rtl/trng_host_ctrl_bus_if.sv | 62 ++++++
 rtl/trng_host_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_trng_host_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trng_host_pkg.sv
// Shared definitions for the TRNG host sequencer: register map, CTRL bit positions,
// bus size encodings and the sequencer state set (W_CALB exists only with TRNG_HOST_CALIB_EN).
package trng_host_pkg;

    localparam logic [5:0] ADDR_CTRL   = 6'd0;
    localparam logic [5:0] ADDR_STATUS = 6'd1;
    localparam logic [5:0] ADDR_CALCYC = 6'd2;
    localparam logic [5:0] ADDR_I1     = 6'd3;
    localparam logic [5:0] ADDR_I2     = 6'd4;
    localparam logic [5:0] ADDR_TRIG   = 6'd5;
    localparam logic [5:0] ADDR_RANDOM = 6'd7;

    localparam int CTRL_RST      = 0;
    localparam int CTRL_EN       = 1;
    localparam int CTRL_SEL_BASE = 2;
    localparam int CTRL_CALIB    = 3;
    localparam int CTRL_READ     = 4;

    localparam logic [1:0] SIZE_NONE = 2'b11;
    localparam logic [1:0] SIZE_32   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE, S_W_RST, S_W_CAL, S_W_I1, S_W_I2, S_W_TRIG, S_W_EN,
`ifdef TRNG_HOST_CALIB_EN
        S_W_CALB,
`endif
        S_POLL, S_W_REQ, S_RD, S_W_CLR, S_OUT, S_W_DIS
    } state_e;

    function automatic logic [31:0] ctrl_word(input logic rst, input logic en, input logic sel,
                                              input logic cal, input logic rd);
        logic [31:0] w;
        w                = 32'd0;
        w[CTRL_RST]      = rst;
        w[CTRL_EN]       = en;
        w[CTRL_SEL_BASE] = sel;
        w[CTRL_CALIB]    = cal;
        w[CTRL_READ]     = rd;
        return w;
    endfunction

endpackage

// File: rtl/trng_host_ctrl_bus_if.sv
// Single-access bus engine: a one-cycle request becomes a registered bus access; reads are
// held until the peripheral signals ready, and done/rdata are reported on that cycle.
module trng_host_bus_if
    import trng_host_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [5:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic [5:0]  o_bus_address,
    output logic [31:0] o_bus_wdata,
    output logic [1:0]  o_bus_write_n,
    output logic [1:0]  o_bus_read_n,
    input  logic [31:0] i_bus_rdata,
    input  logic        i_bus_ready
);

    logic [5:0]  r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_write_n;
    logic [1:0]  r_read_n;
    logic        w_rd_active;

    assign w_rd_active = (r_read_n == SIZE_32);
    assign o_done      = w_rd_active && i_bus_ready;
    assign o_rdata     = i_bus_rdata;

    // Bus drive registers: new request, held read, or idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr    <= 6'd0;
            r_wdata   <= 32'd0;
            r_write_n <= SIZE_NONE;
            r_read_n  <= SIZE_NONE;
        end else if (i_req) begin
            r_addr    <= i_addr;
            r_wdata   <= i_we ? i_wdata : 32'd0;
            r_write_n <= i_we ? SIZE_32 : SIZE_NONE;
            r_read_n  <= i_we ? SIZE_NONE : SIZE_32;
        end else if (w_rd_active && !i_bus_ready) begin
            r_addr    <= r_addr;
            r_wdata   <= r_wdata;
            r_write_n <= r_write_n;
            r_read_n  <= r_read_n;
        end else begin
            r_addr    <= 6'd0;
            r_wdata   <= 32'd0;
            r_write_n <= SIZE_NONE;
            r_read_n  <= SIZE_NONE;
        end
    end

    assign o_bus_address = r_addr;
    assign o_bus_wdata   = r_wdata;
    assign o_bus_write_n = r_write_n;
    assign o_bus_read_n  = r_read_n;

endmodule

// File: rtl/trng_host_ctrl.sv
// TRNG host sequencer: programs the peripheral, polls status, reads random words and streams
// them out. Define TRNG_HOST_CALIB_EN to add the CALIB write step and keep CALIB set afterwards.
module trng_host_ctrl
    import trng_host_pkg::*;
#(
    parameter int POLL_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic [31:0] i_cfg_calib_cycles,
    input  logic [23:0] i_cfg_i1,
    input  logic [23:0] i_cfg_i2,
    input  logic [23:0] i_cfg_trigger,
    input  logic        i_cfg_sel_base,
    output logic [5:0]  o_bus_address,
    output logic [31:0] o_bus_wdata,
    output logic [1:0]  o_bus_write_n,
    output logic [1:0]  o_bus_read_n,
    input  logic [31:0] i_bus_rdata,
    input  logic        i_bus_ready,
    output logic [31:0] o_rnd_data,
    output logic        o_rnd_valid,
    input  logic        i_rnd_ready,
    output logic        o_busy,
    output logic        o_err
);

    localparam logic [15:0] LIMIT = 16'(POLL_LIMIT);
`ifdef TRNG_HOST_CALIB_EN
    localparam logic CAL = 1'b1;
`else
    localparam logic CAL = 1'b0;
`endif

    state_e      r_state, w_state_n;
    logic [15:0] r_poll_cnt, w_cnt_n, w_cnt_inc;
    logic [31:0] r_rnd_data;
    logic        r_rnd_valid, r_busy, r_err, w_err_n, w_cap;
    logic        w_req, w_we, w_bus, w_done;
    logic [5:0]  w_addr;
    logic [31:0] w_wdata, w_rdata;

    assign w_cnt_inc = r_poll_cnt + 16'd1;

    // Next-state, poll counter and error flag.
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_poll_cnt;
        w_err_n   = r_err;
        w_cap     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_n = S_W_RST;
                    w_err_n   = 1'b0;
                end else begin
                    w_state_n = S_IDLE;
                end
            end
            S_W_RST:  w_state_n = S_W_CAL;
            S_W_CAL:  w_state_n = S_W_I1;
            S_W_I1:   w_state_n = S_W_I2;
            S_W_I2:   w_state_n = S_W_TRIG;
            S_W_TRIG: w_state_n = S_W_EN;
`ifdef TRNG_HOST_CALIB_EN
            S_W_EN:   w_state_n = S_W_CALB;
            S_W_CALB: w_state_n = S_POLL;
`else
            S_W_EN:   w_state_n = S_POLL;
`endif
            S_POLL: begin
                if (!w_done) begin
                    w_state_n = S_POLL;
                end else if (i_stop) begin
                    w_state_n = S_W_DIS;
                end else if (w_rdata[0]) begin
                    w_state_n = S_W_REQ;
                end else if (w_cnt_inc == LIMIT) begin
                    w_state_n = S_W_DIS;
                    w_err_n   = 1'b1;
                end else begin
                    w_cnt_n   = w_cnt_inc;
                end
            end
            S_W_REQ: w_state_n = S_RD;
            S_RD: begin
                if (w_done) begin
                    w_cap     = 1'b1;
                    w_state_n = S_W_CLR;
                end else begin
                    w_state_n = S_RD;
                end
            end
            S_W_CLR: w_state_n = S_OUT;
            S_OUT: begin
                if (r_rnd_valid && i_rnd_ready) begin
                    w_state_n = i_stop ? S_W_DIS : S_POLL;
                end else begin
                    w_state_n = S_OUT;
                end
            end
            S_W_DIS: w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase
        if (w_state_n == S_POLL && r_state != S_POLL) begin
            w_cnt_n = 16'd0;
        end else begin
            w_cnt_n = w_cnt_n;
        end
    end

    // Bus request for the state being entered (or a repeated status read after a completed one).
    always_comb begin
        w_bus   = 1'b1;
        w_we    = 1'b1;
        w_addr  = ADDR_CTRL;
        w_wdata = 32'd0;
        case (w_state_n)
            S_W_RST:  w_wdata = ctrl_word(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            S_W_CAL:  begin w_addr = ADDR_CALCYC; w_wdata = i_cfg_calib_cycles; end
            S_W_I1:   begin w_addr = ADDR_I1;     w_wdata = {8'd0, i_cfg_i1}; end
            S_W_I2:   begin w_addr = ADDR_I2;     w_wdata = {8'd0, i_cfg_i2}; end
            S_W_TRIG: begin w_addr = ADDR_TRIG;   w_wdata = {8'd0, i_cfg_trigger}; end
            S_W_EN:   w_wdata = ctrl_word(1'b0, 1'b1, i_cfg_sel_base, 1'b0, 1'b0);
`ifdef TRNG_HOST_CALIB_EN
            S_W_CALB: w_wdata = ctrl_word(1'b0, 1'b1, i_cfg_sel_base, 1'b1, 1'b0);
`endif
            S_POLL:   begin w_we = 1'b0; w_addr = ADDR_STATUS; end
            S_W_REQ:  w_wdata = ctrl_word(1'b0, 1'b1, i_cfg_sel_base, CAL, 1'b1);
            S_RD:     begin w_we = 1'b0; w_addr = ADDR_RANDOM; end
            S_W_CLR:  w_wdata = ctrl_word(1'b0, 1'b1, i_cfg_sel_base, CAL, 1'b0);
            S_W_DIS:  w_wdata = 32'd0;
            default:  w_bus = 1'b0;
        endcase
        w_req = w_bus && ((w_state_n != r_state) || (r_state == S_POLL && w_done));
    end

    // State and registered stream/status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_poll_cnt  <= 16'd0;
            r_rnd_data  <= 32'd0;
            r_rnd_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_poll_cnt  <= w_cnt_n;
            r_rnd_data  <= w_cap ? w_rdata : r_rnd_data;
            r_rnd_valid <= (w_state_n == S_OUT);
            r_busy      <= (w_state_n != S_IDLE);
            r_err       <= w_err_n;
        end
    end

    trng_host_bus_if u_bus_if (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req         (w_req),
        .i_we          (w_we),
        .i_addr        (w_addr),
        .i_wdata       (w_wdata),
        .o_done        (w_done),
        .o_rdata       (w_rdata),
        .o_bus_address (o_bus_address),
        .o_bus_wdata   (o_bus_wdata),
        .o_bus_write_n (o_bus_write_n),
        .o_bus_read_n  (o_bus_read_n),
        .i_bus_rdata   (i_bus_rdata),
        .i_bus_ready   (i_bus_ready)
    );

    assign o_rnd_data  = r_rnd_data;
    assign o_rnd_valid = r_rnd_valid;
    assign o_busy      = r_busy;
    assign o_err       = r_err;

endmodule

// File: tb/tb_trng_host_ctrl.sv
// Self-checking bench for trng_host_ctrl: directed scenarios with literal expectations plus
// a randomized run, all checked every cycle against a transaction-level model of the sequence.
module tb_trng_host_ctrl;

    localparam int LIMIT = 4;
`ifdef TRNG_HOST_CALIB_EN
    localparam int          CH   = 7;
    localparam logic [31:0] CALV = 32'h8;
`else
    localparam int          CH   = 6;
    localparam logic [31:0] CALV = 32'h0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, sel = 1'b0;
    logic        rnd_ready = 1'b0, bus_ready = 1'b1;
    logic [31:0] calc = 32'd0, bus_rdata = 32'd0;
    logic [23:0] i1 = 24'd0, i2 = 24'd0, trig = 24'd0;
    logic [5:0]  o_addr;
    logic [31:0] o_wdata, o_data;
    logic [1:0]  o_wn, o_rn;
    logic        o_valid, o_busy, o_err;

    int checks = 0, errors = 0, cyc_no = 0;

    trng_host_ctrl #(.POLL_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_stop(stop),
        .i_cfg_calib_cycles(calc), .i_cfg_i1(i1), .i_cfg_i2(i2), .i_cfg_trigger(trig),
        .i_cfg_sel_base(sel), .o_bus_address(o_addr), .o_bus_wdata(o_wdata),
        .o_bus_write_n(o_wn), .o_bus_read_n(o_rn), .i_bus_rdata(bus_rdata),
        .i_bus_ready(bus_ready), .o_rnd_data(o_data), .o_rnd_valid(o_valid),
        .i_rnd_ready(rnd_ready), .o_busy(o_busy), .o_err(o_err)
    );

    always #5 clk = ~clk;

    // Peripheral stand-in: status/word responses and ready stalls.
    logic        rnd_mode = 1'b0, st_never = 1'b0;
    int          st_after = 1, stall = 0, poll_seen = 0;
    logic [31:0] word = 32'hDEADBEEF;
    always @(negedge clk) begin
        logic rd_st, rd_rn;
        rd_st = (o_rn == 2'b10) && (o_addr == 6'd1);
        rd_rn = (o_rn == 2'b10) && (o_addr == 6'd7);
        bus_rdata = $urandom;
        if (rnd_mode) begin
            bus_ready = ($urandom_range(0, 3) != 0);
            if (rd_st) bus_rdata[0] = ($urandom_range(0, 2) == 0);
        end else begin
            bus_ready = 1'b1;
            if (rd_rn && stall > 0) begin
                bus_ready = 1'b0;
                stall--;
            end
            if (rd_st) begin
                bus_rdata[0] = !st_never && (poll_seen + 1 >= st_after);
                poll_seen++;
            end
            if (rd_rn) bus_rdata = word;
        end
    end

    // Reference model: where the session is, and what the bus must show there.
    localparam int P_IDLE = 0, P_CHAIN = 1, P_POLL = 2, P_REQ = 3, P_RD = 4,
                   P_CLR = 5, P_OUT = 6, P_DIS = 7;
    int          m_pos = P_IDLE, m_k = 0, m_cnt = 0;
    logic        m_init = 1'b0, m_err = 1'b0;
    logic [31:0] m_data = 32'd0;
    logic [5:0]  e_addr = 6'd0;
    logic [31:0] e_wdata = 32'd0;
    logic [1:0]  e_wn = 2'b11, e_rn = 2'b11;

    always @(posedge clk) begin
        logic        done;
        logic [31:0] s;
        done = (e_rn == 2'b10) && bus_ready;
        if (!rst_n) begin
            m_pos  = P_IDLE;
            m_data = 32'd0;
            m_err  = 1'b0;
        end else begin
            case (m_pos)
                P_IDLE: if (start) begin m_pos = P_CHAIN; m_k = 0; m_err = 1'b0; end
                P_CHAIN: begin
                    m_k++;
                    if (m_k == CH) begin m_pos = P_POLL; m_cnt = 0; end
                end
                P_POLL: if (done) begin
                    if (stop) m_pos = P_DIS;
                    else if (bus_rdata[0]) m_pos = P_REQ;
                    else begin
                        m_cnt++;
                        if (m_cnt == LIMIT) begin m_err = 1'b1; m_pos = P_DIS; end
                    end
                end
                P_REQ: m_pos = P_RD;
                P_RD:  if (done) begin m_data = bus_rdata; m_pos = P_CLR; end
                P_CLR: m_pos = P_OUT;
                P_OUT: if (rnd_ready) begin
                    m_pos = stop ? P_DIS : P_POLL;
                    m_cnt = 0;
                end
                default: m_pos = P_IDLE;
            endcase
        end
        s = sel ? 32'h4 : 32'h0;
        e_addr = 6'd0; e_wdata = 32'd0; e_wn = 2'b11; e_rn = 2'b11;
        case (m_pos)
            P_CHAIN: begin
                e_wn = 2'b10;
                case (m_k)
                    0: e_wdata = 32'h1;
                    1: begin e_addr = 6'd2; e_wdata = calc; end
                    2: begin e_addr = 6'd3; e_wdata = {8'd0, i1}; end
                    3: begin e_addr = 6'd4; e_wdata = {8'd0, i2}; end
                    4: begin e_addr = 6'd5; e_wdata = {8'd0, trig}; end
                    5: e_wdata = 32'h2 | s;
                    default: e_wdata = 32'hA | s;
                endcase
            end
            P_POLL: begin e_rn = 2'b10; e_addr = 6'd1; end
            P_REQ:  begin e_wn = 2'b10; e_wdata = 32'h12 | s | CALV; end
            P_RD:   begin e_rn = 2'b10; e_addr = 6'd7; end
            P_CLR:  begin e_wn = 2'b10; e_wdata = 32'h02 | s | CALV; end
            P_DIS:  e_wn = 2'b10;
            default: e_wn = 2'b11;
        endcase
        m_init = 1'b1;
        cyc_no++;
    end

    // Compare process: every cycle, all outputs against the model.
    always @(negedge clk) begin
        if (m_init) begin
            checks++;
            if ({o_addr, o_wdata, o_wn, o_rn, o_data, o_valid, o_busy, o_err} !==
                {e_addr, e_wdata, e_wn, e_rn, m_data, (m_pos == P_OUT), (m_pos != P_IDLE), m_err}) begin
                errors++;
                $display("FAIL model cyc=%0d act a=%h w=%h wn=%b rn=%b d=%h v=%b b=%b e=%b exp a=%h w=%h wn=%b rn=%b d=%h v=%b b=%b e=%b",
                         cyc_no, o_addr, o_wdata, o_wn, o_rn, o_data, o_valid, o_busy, o_err,
                         e_addr, e_wdata, e_wn, e_rn, m_data, (m_pos == P_OUT), (m_pos != P_IDLE), m_err);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int n;
        cyc(3);
        chk("rst_bus", {o_addr, o_wdata, o_wn, o_rn}, {6'd0, 32'd0, 2'b11, 2'b11});
        chk("rst_stat", {o_data, o_valid, o_busy, o_err}, {32'd0, 3'b000});
        rst_n = 1'b1;
        cyc(1);

        // Nominal session, third status read ready, held off by the consumer.
        sel = 1'b1; calc = 32'h12345678; i1 = 24'hABCDEF; i2 = 24'h000111; trig = 24'h222333;
        st_after = 3; poll_seen = 0; word = 32'hDEADBEEF; rnd_ready = 1'b0;
        start = 1'b1; cyc(1); start = 1'b0;
        chk("w_rst", {o_wn, o_addr, o_wdata}, {2'b10, 6'd0, 32'h1});
        cyc(1);
        chk("w_cal", {o_wn, o_addr, o_wdata}, {2'b10, 6'd2, 32'h12345678});
        cyc(3);
        chk("w_trig", {o_wn, o_addr, o_wdata}, {2'b10, 6'd5, 32'h00222333});
        cyc(1);
        chk("w_en", {o_wn, o_addr, o_wdata}, {2'b10, 6'd0, 32'h6});
        cyc(CH - 5);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            if (o_rn == 2'b10 && o_addr == 6'd1) n++;
            cyc(1);
        end
        chk("n_polls", 64'(n), 64'd3);
        chk("w_req", {o_wn, o_addr, o_wdata}, {2'b10, 6'd0, 32'h16 | CALV});
        cyc(1);
        chk("rd_rnd", {o_rn, o_wn, o_addr}, {2'b10, 2'b11, 6'd7});
        cyc(1);
        chk("w_clr", {o_wn, o_addr, o_wdata}, {2'b10, 6'd0, 32'h06 | CALV});
        cyc(1);
        chk("out", {o_valid, o_data}, {1'b1, 32'hDEADBEEF});
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("bp_hold", {o_valid, o_data, o_wn, o_rn}, {1'b1, 32'hDEADBEEF, 2'b11, 2'b11});
        end
        stop = 1'b1; rnd_ready = 1'b1;
        cyc(1);
        stop = 1'b0; rnd_ready = 1'b0;
        chk("stop_dis", {o_wn, o_rn, o_addr, o_wdata}, {2'b10, 2'b11, 6'd0, 32'd0});
        cyc(1);
        chk("stop_idle", {o_busy, o_valid, o_rn, o_wn}, {2'b00, 2'b11, 2'b11});

        // Timeout: status never ready.
        st_never = 1'b1;
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(CH);
        n = 0;
        for (int i = 0; i < LIMIT + 1; i++) begin
            if (o_rn == 2'b10 && o_addr == 6'd1) n++;
            if (i < LIMIT) cyc(1);
        end
        chk("to_polls", 64'(n), 64'd4);
        chk("to_dis", {o_wn, o_addr, o_wdata}, {2'b10, 6'd0, 32'd0});
        cyc(1);
        chk("to_err", {o_err, o_busy, o_rn, o_wn}, {2'b10, 2'b11, 2'b11});
        start = 1'b1; cyc(1); start = 1'b0;
        chk("err_clr", {o_err, o_busy}, {2'b01});
        stop = 1'b1;
        cyc(CH - 1);
        chk("stop_in_chain", {o_wn, o_busy}, {2'b10, 1'b1});
        cyc(2);
        chk("stop_at_poll", {o_wn, o_rn, o_wdata}, {2'b10, 2'b11, 32'd0});
        stop = 1'b0; st_never = 1'b0;
        cyc(2);

        // Read stall during RD, then reset in the middle of polling.
        st_after = 1; poll_seen = 0; stall = 3; word = 32'h0BADF00D; rnd_ready = 1'b1;
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(CH + 2);
        for (int i = 0; i < 4; i++) begin
            chk("stall_hold", {o_rn, o_addr, o_data}, {2'b10, 6'd7, 32'hDEADBEEF});
            cyc(1);
        end
        chk("stall_cap", {o_data, o_wn, o_wdata}, {32'h0BADF00D, 2'b10, 32'h06 | CALV});
        st_never = 1'b1;
        cyc(1);
        chk("out2", {o_valid, o_data}, {1'b1, 32'h0BADF00D});
        cyc(1);
        chk("repoll", {o_rn, o_addr}, {2'b10, 6'd1});
        rst_n = 1'b0;
        cyc(1);
        chk("mid_rst", {o_addr, o_wdata, o_wn, o_rn, o_valid, o_busy, o_err},
            {6'd0, 32'd0, 2'b11, 2'b11, 3'b000});
        chk("mid_rst_data", 64'(o_data), 64'd0);
        rst_n = 1'b1; st_never = 1'b0; rnd_ready = 1'b0;
        cyc(1);

        // Randomized run against the model.
        rnd_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            start     = ($urandom_range(0, 7) == 0);
            stop      = ($urandom_range(0, 15) == 0);
            rnd_ready = $urandom_range(0, 1) == 1;
            sel       = $urandom_range(0, 1) == 1;
            calc = $urandom; i1 = 24'($urandom); i2 = 24'($urandom); trig = 24'($urandom);
            rst_n     = ($urandom_range(0, 199) != 0);
            cyc(1);
        end
        rst_n = 1'b1; start = 1'b0; stop = 1'b0;
        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
